adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
Serial-ADC responder: the slave end of the 3-wire ADC link driven by the BEMF controller's exchange initiator. It decodes the start bit and 4-bit command (single/diff flag plus 3-bit channel), then returns a null bit followed by a 12-bit result, MSB first, from a host-writable 8-channel value file. It serves as an FPGA-side ADC emulator for bring-up and hardware-in-loop tests of the BEMF controller, with no external ADC fitted.

Parameters:
DATA_BITS, 12, result width returned after the null bit
NUM_CHAN, 8, channel value registers (channel index is 3 bits)
SYNC_STAGES, 2, synchronizer depth on SerialClk, Cs and SerialIn

Ports:
Clk  in  1  system clock, single clock domain
Reset  in  1  asynchronous, active-high reset
SerialClk  in  1  link clock from initiator; asynchronous, half period ≥ 8 Clk
Cs  in  1  chip select, active low
SerialIn  in  1  command data from initiator
SerialOut  out  1  result data to initiator
SerialOe  out  1  high = responder drives the shared data line
Addr  in  3  channel register select
DataWr  in  12  channel value
Wr  in  1  write strobe, one Clk
CmdValid  out  1  one-Clk pulse when the command is complete
CmdOut  out  4  last command {sgl_diff, ch[2:0]}, held until the next command
FrameError  out  1  one-Clk pulse when Cs rises mid-frame
Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async) values: SerialOut=0, SerialOe=0, CmdValid=0, CmdOut=0, FrameError=0, all channel registers=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops. Edge detect on synced SerialClk gives pos and neg. All link timing below refers to these synced edges.
- The link samples on SerialClk rising edges and changes data on falling edges.
- Posedges are numbered from the first posedge with Cs low and SerialIn=1; that posedge is P1.
- State IDLE: while Cs is low, a posedge with SerialIn=0 is ignored (leading zeros allowed). A posedge with SerialIn=1 moves to CMD with bitcnt=3.
- State CMD: each posedge shifts SerialIn into cmd[bitcnt], MSB first, and decrements bitcnt. On the posedge with bitcnt=0 (P5):
  - latch CmdOut and pulse CmdValid;
  - compute result and load shift register {1'b0, result[11:0]};
  - go to TURN.
- Result rule:
  - sgl_diff=1: result = ChanReg[ch].
  - sgl_diff=0: result = ChanReg[ch] − ChanReg[ch^1], saturated to 0 when negative; 12-bit unsigned.
- State TURN: SerialOe stays 0 through P6. At the negedge following P6 (N6), assert SerialOe with SerialOut=0, then go to SHIFT with bitcnt=12.
- State SHIFT:
  - N7 drives shift[12] (null bit, 0), sampled by the initiator at P8.
  - Each following negedge drives the next bit, down to bit0 at N19, sampled at P20.
  - N20 deasserts SerialOe, drives SerialOut=0, and goes to DONE.
- State DONE: wait for Cs high, then go to IDLE. Further posedges are ignored.
- Cs rise (synced) in CMD, TURN or SHIFT:
  - abort to IDLE, SerialOe=0, SerialOut=0, one-Clk FrameError pulse;
  - CmdOut keeps its previous value if the abort happens in CMD.
- Cs rise in IDLE or DONE: no error.
- Host write: ChanReg[Addr] <= DataWr when Wr is high, at any time.
  - The result is snapshotted at P5, so writes after P5 do not alter the frame in flight.
  - A write on the same Clk as the P5 snapshot is not visible in that frame (old value used).
- Busy = state != IDLE.

Decomposition:
- Shared package: state encoding (IDLE, CMD, TURN, SHIFT, DONE), CMD_BITS=4, null-bit constant, the sgl_diff bit index.
- One natural sub-module: adc_link_sync, holding the SYNC_STAGES synchronizers plus SerialClk pos/neg edge detect.
- The result subtract/saturate stays inline.

Test Plan:
- ChanReg[5]=0xABC; frame with start, cmd 1101 (sgl, ch5) -> CmdValid at P5, CmdOut=0xD, 13 bits sampled at P8..P20 = 0,1010_1011_1100; SerialOe high from N6 to N20.
- ChanReg[2]=0x300, ChanReg[3]=0x100; cmd 0010 (diff, ch2) -> returns 0x200. Swap values -> returns 0x000 (saturation).
- Three leading zeros with Cs low before the start bit -> same response as the first case; no error.
- Cs raised after P3 -> FrameError pulse, SerialOe=0, Busy=0; the next full frame responds correctly.
- Write ChanReg[5]=0x111 between P6 and P20 of a frame using ch5 -> frame returns the old 0xABC; the next frame returns 0x111.
- Assert Reset during SHIFT -> SerialOe and SerialOut go to 0 immediately (async) and all ChanReg read back 0 in the next frame.

Source files
------------

// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the serial-ADC responder (ADC emulator on the
// slave end of the 3-wire link).
package adc_responder_pkg;
    typedef enum logic [2:0] {IDLE, CMD, TURN, SHIFT, DONE} stateT;

    localparam int   CMD_BITS     = 4;
    localparam int   CH_W         = CMD_BITS - 1;
    localparam int   SGL_DIFF_IDX = CMD_BITS - 1;
    localparam logic NULL_BIT     = 1'b0;
endpackage

// File: rtl/adc_link_sync.sv
// Synchronizers for the asynchronous link inputs plus SerialClk edge detect.
// Cs resets high so an unpowered initiator does not look like a selected frame.
module adc_link_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic SerialClk,
    input  logic Cs,
    input  logic SerialIn,
    output logic csSync,
    output logic dataSync,
    output logic clkPos,
    output logic clkNeg
);
    logic [SYNC_STAGES-1:0] clkPipe, csPipe, dataPipe;
    logic clkPrev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clkPipe  <= '0;
            csPipe   <= '1;
            dataPipe <= '0;
            clkPrev  <= 1'b0;
        end else begin
            clkPipe  <= (clkPipe << 1) | SYNC_STAGES'(SerialClk);
            csPipe   <= (csPipe << 1) | SYNC_STAGES'(Cs);
            dataPipe <= (dataPipe << 1) | SYNC_STAGES'(SerialIn);
            clkPrev  <= clkPipe[SYNC_STAGES-1];
        end
    end

    assign csSync   = csPipe[SYNC_STAGES-1];
    assign dataSync = dataPipe[SYNC_STAGES-1];
    assign clkPos   = clkPipe[SYNC_STAGES-1] & ~clkPrev;
    assign clkNeg   = ~clkPipe[SYNC_STAGES-1] & clkPrev;
endmodule

// File: rtl/adc_responder.sv
// Serial-ADC responder: decodes start bit + 4-bit command, then returns a null
// bit and a DATA_BITS result (MSB first) from a host-writable channel file.
module adc_responder
    import adc_responder_pkg::*;
#(
    parameter int DATA_BITS   = 12,
    parameter int NUM_CHAN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 SerialClk,
    input  logic                 Cs,
    input  logic                 SerialIn,
    output logic                 SerialOut,
    output logic                 SerialOe,
    input  logic [CH_W-1:0]      Addr,
    input  logic [DATA_BITS-1:0] DataWr,
    input  logic                 Wr,
    output logic                 CmdValid,
    output logic [CMD_BITS-1:0]  CmdOut,
    output logic                 FrameError,
    output logic                 Busy
);
    localparam int SC_W = $clog2(DATA_BITS + 2);

    logic csSync, dataSync, clkPos, clkNeg;

    adc_link_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .Clk(Clk), .Reset(Reset), .SerialClk(SerialClk), .Cs(Cs), .SerialIn(SerialIn),
        .csSync(csSync), .dataSync(dataSync), .clkPos(clkPos), .clkNeg(clkNeg)
    );

    logic [NUM_CHAN-1:0][DATA_BITS-1:0] chanReg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)   chanReg       <= '0;
        else if (Wr) chanReg[Addr] <= DataWr;
    end

    stateT               state;
    logic [CMD_BITS-2:0] cmdHi;
    logic [1:0]          bitCnt;
    logic [DATA_BITS:0]  shiftReg;
    logic [SC_W-1:0]     shiftCnt;
    logic                turnArmed;

    // Full command as of the final command posedge, including the bit arriving now.
    logic [CMD_BITS-1:0]  cmdFull;
    logic [DATA_BITS-1:0] chA, chB, result;
    logic                 abort;

    assign cmdFull = {cmdHi, dataSync};
    assign chA     = chanReg[cmdFull[CH_W-1:0]];
    assign chB     = chanReg[cmdFull[CH_W-1:0] ^ CH_W'(1)];
    assign result  = cmdFull[SGL_DIFF_IDX] ? chA : ((chA >= chB) ? chA - chB : '0);
    assign abort   = csSync && (state == CMD || state == TURN || state == SHIFT);
    assign Busy    = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cmdHi      <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            shiftCnt   <= '0;
            turnArmed  <= 1'b0;
            SerialOut  <= 1'b0;
            SerialOe   <= 1'b0;
            CmdValid   <= 1'b0;
            CmdOut     <= '0;
            FrameError <= 1'b0;
        end else begin
            CmdValid   <= 1'b0;
            FrameError <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                SerialOe   <= 1'b0;
                SerialOut  <= 1'b0;
                FrameError <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (!csSync && clkPos && dataSync) begin
                        state  <= CMD;
                        bitCnt <= 2'd3;
                    end
                    CMD: if (clkPos) begin
                        cmdHi  <= {cmdHi[CMD_BITS-3:0], dataSync};
                        bitCnt <= bitCnt - 2'd1;
                        if (bitCnt == 2'd0) begin
                            CmdOut    <= cmdFull;
                            CmdValid  <= 1'b1;
                            shiftReg  <= {NULL_BIT, result};
                            turnArmed <= 1'b0;
                            state     <= TURN;
                        end
                    end
                    // Wait for the posedge after the command, then take the line on the next negedge.
                    TURN: if (clkPos) begin
                        turnArmed <= 1'b1;
                    end else if (clkNeg && turnArmed) begin
                        SerialOe  <= 1'b1;
                        SerialOut <= 1'b0;
                        shiftCnt  <= SC_W'(DATA_BITS + 1);
                        state     <= SHIFT;
                    end
                    SHIFT: if (clkNeg) begin
                        if (shiftCnt == '0) begin
                            SerialOe  <= 1'b0;
                            SerialOut <= 1'b0;
                            state     <= DONE;
                        end else begin
                            SerialOut <= shiftReg[DATA_BITS];
                            shiftReg  <= {shiftReg[DATA_BITS-1:0], 1'b0};
                            shiftCnt  <= shiftCnt - SC_W'(1);
                        end
                    end
                    DONE: if (csSync) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: acts as the link initiator and host, checking each
// frame against a channel-file model of the result rules.
module tb_adc_responder;
    localparam int HALF = 10;

    logic        Clk = 1'b0, Reset = 1'b1, SerialClk = 1'b0, Cs = 1'b1, SerialIn = 1'b0, Wr = 1'b0;
    logic [2:0]  Addr = '0;
    logic [11:0] DataWr = '0;
    logic        SerialOut, SerialOe, CmdValid, FrameError, Busy;
    logic [3:0]  CmdOut;

    adc_responder dut (
        .Clk(Clk), .Reset(Reset), .SerialClk(SerialClk), .Cs(Cs), .SerialIn(SerialIn),
        .SerialOut(SerialOut), .SerialOe(SerialOe), .Addr(Addr), .DataWr(DataWr), .Wr(Wr),
        .CmdValid(CmdValid), .CmdOut(CmdOut), .FrameError(FrameError), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int cvCnt = 0, feCnt = 0;
    always @(posedge Clk) begin
        if (CmdValid)   cvCnt <= cvCnt + 1;
        if (FrameError) feCnt <= feCnt + 1;
    end

    int          errors = 0, checks = 0;
    logic [11:0] chan [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] refResult(input logic [3:0] c);
        int d;
        if (c[3]) return chan[c[2:0]];
        d = int'(chan[c[2:0]]) - int'(chan[c[2:0] ^ 3'd1]);
        return (d < 0) ? 12'd0 : 12'(d);
    endfunction

    task automatic hostWrite(input logic [2:0] a, input logic [11:0] d);
        @(negedge Clk);
        Addr = a; DataWr = d; Wr = 1'b1;
        @(negedge Clk);
        Wr = 1'b0;
        chan[a] = d;
    endtask

    // rel numbers posedges from the start bit (P1); leading zeros have rel <= 0.
    task automatic runFrame(input int lead, input logic [3:0] cmd, input int abortAfter,
                            input int resetAfter, input int wrAfter, input logic [2:0] wa,
                            input logic [11:0] wd, output logic [12:0] bits, output logic [21:1] oe);
        int rel;
        bits = '0; oe = '0;
        Cs = 1'b0;
        repeat (6) @(negedge Clk);
        for (int k = 1; k <= lead + 21; k++) begin
            rel = k - lead;
            SerialIn = (rel <= 0) ? 1'b0 : (rel == 1) ? 1'b1 : (rel <= 5) ? cmd[5-rel] : 1'b0;
            repeat (HALF) @(negedge Clk);
            SerialClk = 1'b1;
            if (rel >= 8 && rel <= 20) bits[20-rel] = SerialOut;
            if (rel >= 1) oe[rel] = SerialOe;
            repeat (HALF) @(negedge Clk);
            SerialClk = 1'b0;
            if (rel == abortAfter) begin
                Cs = 1'b1; SerialIn = 1'b0;
                repeat (6) @(negedge Clk);
                return;
            end
            if (rel == resetAfter) begin
                Reset = 1'b1;
                #1;
                chk("rst.oe", SerialOe, 0);
                chk("rst.out", SerialOut, 0);
                chk("rst.busy", Busy, 0);
                repeat (2) @(negedge Clk);
                Reset = 1'b0; Cs = 1'b1; SerialIn = 1'b0;
                repeat (6) @(negedge Clk);
                return;
            end
            if (rel == wrAfter) hostWrite(wa, wd);
        end
        Cs = 1'b1; SerialIn = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic goodFrame(input string tag, input int lead, input logic [3:0] cmd,
                             input int wrAfter, input logic [2:0] wa, input logic [11:0] wd);
        logic [11:0] e;
        logic [12:0] bits;
        logic [21:1] oe, expOe;
        int cv0, fe0;
        e = refResult(cmd);
        cv0 = cvCnt; fe0 = feCnt;
        for (int i = 1; i <= 21; i++) expOe[i] = (i >= 7 && i <= 20);
        runFrame(lead, cmd, -99, -99, wrAfter, wa, wd, bits, oe);
        chk({tag, ".data"}, bits, {1'b0, e});
        chk({tag, ".oe"}, oe, expOe);
        chk({tag, ".cmdvalid"}, cvCnt - cv0, 1);
        chk({tag, ".cmdout"}, CmdOut, cmd);
        chk({tag, ".ferr"}, feCnt - fe0, 0);
        chk({tag, ".busy"}, Busy, 0);
    endtask

    initial begin
        logic [12:0] bits;
        logic [21:1] oe;
        logic [3:0]  cmd;
        int cv0, fe0;
        for (int i = 0; i < 8; i++) chan[i] = '0;

        repeat (3) @(negedge Clk);
        chk("reset.out", SerialOut, 0);
        chk("reset.oe", SerialOe, 0);
        chk("reset.cmdvalid", CmdValid, 0);
        chk("reset.cmdout", CmdOut, 0);
        chk("reset.ferr", FrameError, 0);
        chk("reset.busy", Busy, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        hostWrite(3'd5, 12'hABC);
        goodFrame("sgl5", 0, 4'hD, -99, 3'd0, 12'd0);

        hostWrite(3'd2, 12'h300);
        hostWrite(3'd3, 12'h100);
        goodFrame("diff2", 0, 4'h2, -99, 3'd0, 12'd0);
        hostWrite(3'd2, 12'h100);
        hostWrite(3'd3, 12'h300);
        goodFrame("diff2sat", 0, 4'h2, -99, 3'd0, 12'd0);

        goodFrame("lead3", 3, 4'hD, -99, 3'd0, 12'd0);

        // Abort in CMD: CmdOut must keep the last completed command.
        cv0 = cvCnt; fe0 = feCnt;
        runFrame(0, 4'hA, 3, -99, -99, 3'd0, 12'd0, bits, oe);
        chk("abort.ferr", feCnt - fe0, 1);
        chk("abort.oe", SerialOe, 0);
        chk("abort.busy", Busy, 0);
        chk("abort.cmdvalid", cvCnt - cv0, 0);
        chk("abort.cmdout", CmdOut, 4'hD);
        goodFrame("afterabort", 0, 4'hD, -99, 3'd0, 12'd0);

        goodFrame("midwrite", 0, 4'hD, 10, 3'd5, 12'h111);
        goodFrame("postwrite", 0, 4'hD, -99, 3'd0, 12'd0);

        for (int r = 0; r < 4; r++) begin
            hostWrite(3'($urandom_range(0, 7)), 12'($urandom));
            hostWrite(3'($urandom_range(0, 7)), 12'($urandom));
            cmd = 4'($urandom);
            goodFrame("rand", $urandom_range(0, 2), cmd, -99, 3'd0, 12'd0);
        end

        for (int i = 0; i < 8; i++) hostWrite(3'(i), 12'h800 + 12'(i));
        runFrame(0, 4'hD, -99, 12, -99, 3'd0, 12'd0, bits, oe);
        for (int i = 0; i < 8; i++) chan[i] = '0;
        chk("rst.cmdout", CmdOut, 0);
        for (int i = 0; i < 8; i++) goodFrame("rstread", 0, {1'b1, 3'(i)}, -99, 3'd0, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
